// File: rtl/arm_pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage ARM pipeline: per-stage enables/flushes, multi-cycle
// Execute sequencing and a saturating stall-cycle counter. Outputs are combinational, same cycle.
module arm_pipeline_stall_ctrl #(
   parameter int MultCycles = 4,
   parameter int CntWidth   = 4
) (
   input  logic        i_CLK,
   input  logic        i_RESET,
   input  logic        i_LoadUse,
   input  logic        i_BranchTaken_E,
   input  logic        i_MultiStart_E,
   input  logic        i_MemWait,
   input  logic        i_CountClear,
   output logic        o_Enable_F,
   output logic        o_Enable_D,
   output logic        o_Enable_E,
   output logic        o_Enable_M,
   output logic        o_Enable_W,
   output logic        o_Flush_D,
   output logic        o_Flush_E,
   output logic        o_Flush_M,
   output logic        o_Busy,
   output logic [31:0] o_StallCycles
);

   typedef enum logic {RUN, MULT} state_t;

   localparam logic [CntWidth-1:0] LoadVal = CntWidth'(MultCycles - 2);

   state_t              r_State, w_NextState;
   logic [CntWidth-1:0] r_Cnt, w_NextCnt;
   logic [31:0]         r_StallCycles;

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         r_State       <= RUN;
         r_Cnt         <= '0;
         r_StallCycles <= '0;
      end else begin
         r_State <= w_NextState;
         r_Cnt   <= w_NextCnt;
         if (i_CountClear)
            r_StallCycles <= '0;
         else if (!o_Enable_F && (r_StallCycles != 32'hFFFF_FFFF))
            r_StallCycles <= r_StallCycles + 32'd1;
      end
   end

   always_comb begin
      w_NextState = r_State;
      w_NextCnt   = r_Cnt;
      o_Enable_F  = 1'b1;
      o_Enable_D  = 1'b1;
      o_Enable_E  = 1'b1;
      o_Enable_M  = 1'b1;
      o_Enable_W  = 1'b1;
      o_Flush_D   = 1'b0;
      o_Flush_E   = 1'b0;
      o_Flush_M   = 1'b0;
      o_Busy      = 1'b0;

      if (i_RESET) begin
         w_NextState = RUN;
         w_NextCnt   = '0;
      end else if (i_MemWait) begin
         // The multiplier keeps counting while memory freezes the pipe.
         o_Enable_F = 1'b0;
         o_Enable_D = 1'b0;
         o_Enable_E = 1'b0;
         o_Enable_M = 1'b0;
         o_Enable_W = 1'b0;
         o_Busy     = (r_State == MULT);
         if ((r_State == MULT) && (r_Cnt != '0))
            w_NextCnt = r_Cnt - CntWidth'(1);
      end else if ((r_State == MULT) && (r_Cnt != '0)) begin
         o_Enable_F = 1'b0;
         o_Enable_D = 1'b0;
         o_Enable_E = 1'b0;
         o_Flush_M  = 1'b1;
         o_Busy     = 1'b1;
         w_NextCnt  = r_Cnt - CntWidth'(1);
      end else if ((r_State == RUN) && i_MultiStart_E) begin
         o_Enable_F  = 1'b0;
         o_Enable_D  = 1'b0;
         o_Enable_E  = 1'b0;
         o_Flush_M   = 1'b1;
         o_Busy      = 1'b1;
         w_NextCnt   = LoadVal;
         w_NextState = MULT;
      end else begin
         if (r_State == MULT) begin
            o_Busy      = 1'b1;
            w_NextState = RUN;
         end
         if (i_BranchTaken_E) begin
            o_Flush_D = 1'b1;
            o_Flush_E = 1'b1;
         end else if (i_LoadUse) begin
            o_Enable_F = 1'b0;
            o_Enable_D = 1'b0;
            o_Flush_E  = 1'b1;
         end
      end
   end

   assign o_StallCycles = r_StallCycles;

endmodule

// File: tb/tb_arm_pipeline_stall_ctrl.sv
// Directed plus randomized checks of arm_pipeline_stall_ctrl against a rule-level reference model.
module tb_arm_pipeline_stall_ctrl;

   localparam int MC = 4;

   logic        i_CLK = 1'b0;
   logic        i_RESET, i_LoadUse, i_BranchTaken_E, i_MultiStart_E, i_MemWait, i_CountClear;
   logic        o_Enable_F, o_Enable_D, o_Enable_E, o_Enable_M, o_Enable_W;
   logic        o_Flush_D, o_Flush_E, o_Flush_M, o_Busy;
   logic [31:0] o_StallCycles;

   int checks = 0;
   int errors = 0;

   // Reference model: whether an op is in flight and how many stall cycles remain.
   bit          m_inop;
   int          m_left;
   logic [31:0] m_stall;
   logic [8:0]  m_exp;

   arm_pipeline_stall_ctrl #(.MultCycles(MC), .CntWidth(4)) dut (
      .i_CLK(i_CLK), .i_RESET(i_RESET), .i_LoadUse(i_LoadUse),
      .i_BranchTaken_E(i_BranchTaken_E), .i_MultiStart_E(i_MultiStart_E),
      .i_MemWait(i_MemWait), .i_CountClear(i_CountClear),
      .o_Enable_F(o_Enable_F), .o_Enable_D(o_Enable_D), .o_Enable_E(o_Enable_E),
      .o_Enable_M(o_Enable_M), .o_Enable_W(o_Enable_W),
      .o_Flush_D(o_Flush_D), .o_Flush_E(o_Flush_E), .o_Flush_M(o_Flush_M),
      .o_Busy(o_Busy), .o_StallCycles(o_StallCycles)
   );

   always #5 i_CLK = ~i_CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected {EnF,EnD,EnE,EnM,EnW,FlD,FlE,FlM,Busy} from the priority rules.
   function automatic logic [8:0] model_out();
      if (i_RESET)                          return 9'b11111_000_0;
      if (i_MemWait)                        return {8'b00000_000, m_inop};
      if (m_inop && m_left > 0)             return 9'b00011_001_1;
      if (!m_inop && i_MultiStart_E)        return 9'b00011_001_1;
      if (i_BranchTaken_E)                  return {8'b11111_110, m_inop};
      if (i_LoadUse)                        return {8'b00111_010, m_inop};
      return {8'b11111_000, m_inop};
   endfunction

   task automatic model_next();
      if (i_RESET) begin
         m_inop = 0; m_left = 0; m_stall = 0;
         return;
      end
      if (i_CountClear)                            m_stall = 0;
      else if (!m_exp[8] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (i_MemWait) begin
         if (m_inop && m_left > 0) m_left--;
      end else if (m_inop && m_left > 0) begin
         m_left--;
      end else if (!m_inop && i_MultiStart_E) begin
         m_inop = 1; m_left = MC - 2;
      end else if (m_inop) begin
         m_inop = 0;
      end
   endtask

   task automatic step(input logic rst, lu, br, ms, mw, clr);
      i_RESET = rst; i_LoadUse = lu; i_BranchTaken_E = br;
      i_MultiStart_E = ms; i_MemWait = mw; i_CountClear = clr;
      #1;
      m_exp = model_out();
      chk("outputs", {23'd0, o_Enable_F, o_Enable_D, o_Enable_E, o_Enable_M, o_Enable_W,
                      o_Flush_D, o_Flush_E, o_Flush_M, o_Busy}, {23'd0, m_exp});
      chk("stall_cnt", o_StallCycles, m_stall);
      @(posedge i_CLK);
      model_next();
      @(negedge i_CLK);
   endtask

   initial begin
      m_inop = 0; m_left = 0; m_stall = 0;
      i_RESET = 1; i_LoadUse = 1; i_BranchTaken_E = 1;
      i_MultiStart_E = 1; i_MemWait = 1; i_CountClear = 1;
      @(negedge i_CLK);

      // Reset with every input high
      step(1, 1, 1, 1, 1, 1);
      step(1, 1, 1, 1, 1, 1);
      chk("reset_stall_zero", o_StallCycles, 32'd0);

      // Plain multi-cycle op
      step(0, 0, 0, 1, 0, 0);
      chk("mult_entry_busy", {31'd0, o_Busy}, 32'd0 + 1);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("mult_stall3", o_StallCycles, 32'd3);

      // Load-use alone, then with branch
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Freeze right after entry; op still occupies E for MC cycles
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("freeze_busy_clear", {31'd0, o_Busy}, 32'd0);

      // Branch held through the whole sequence
      for (int i = 0; i < MC; i++) step(0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Back-to-back ops and reset mid-op
      for (int i = 0; i < 2 * MC; i++) step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Saturation and clear
      force dut.r_StallCycles = 32'hFFFF_FFFE;
      #1;
      release dut.r_StallCycles;
      m_stall = 32'hFFFF_FFFE;
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("stall_saturated", o_StallCycles, 32'hFFFF_FFFF);
      step(0, 0, 0, 0, 1, 1);
      chk("stall_cleared", o_StallCycles, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 30) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
